// File: rtl/aquarium_status_reader.sv
// aquarium_status_reader: snapshots the four tank-status registers and streams them
// as a 6-byte frame (header, clean, temp, food, salt, checksum) over valid/ready.
module aquarium_status_reader #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         AUTO_PERIOD = 0,
  parameter int         CNT_W       = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] Q_tank_cleanliness,
  input  logic [7:0] Q_tank_temperature,
  input  logic [7:0] Q_tank_food_storage,
  input  logic [7:0] Q_tank_saltiness,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       missed
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [2:0] idx, nidx;
  logic [7:0] s_clean, s_temp, s_food, s_salt, chk, next_byte;
  logic tick, trig;
  generate
    if (AUTO_PERIOD > 0) begin : g_tmr
      logic [CNT_W-1:0] cnt;
      assign tick = cnt == CNT_W'(AUTO_PERIOD - 1);
      always_ff @(posedge CLK or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end else begin : g_no_tmr
      assign tick = 1'b0;
    end
  endgenerate
  assign trig = start | tick;
  assign chk  = s_clean + s_temp + s_food + s_salt;
  assign nidx = idx + 3'd1;
  always_comb
    next_byte = nidx == 3'd1 ? s_clean :
                nidx == 3'd2 ? s_temp  :
                nidx == 3'd3 ? s_food  :
                nidx == 3'd4 ? s_salt  : chk;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      s_clean    <= '0;
      s_temp     <= '0;
      s_food     <= '0;
      s_salt     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      missed     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      missed     <= 1'b0;
      if (state == IDLE) begin
        if (trig) begin
          s_clean   <= Q_tank_cleanliness;
          s_temp    <= Q_tank_temperature;
          s_food    <= Q_tank_food_storage;
          s_salt    <= Q_tank_saltiness;
          idx       <= '0;
          state     <= SEND;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          out_data  <= HEADER;
        end
      end else begin
        missed <= trig;
        if (out_valid && out_ready) begin
          if (idx == 3'd5) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b1;
          end else begin
            idx      <= nidx;
            out_data <= next_byte;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_aquarium_status_reader.sv
// tb_aquarium_status_reader: random and directed frames checked by a scoreboard
// against a frame-level reference model; a second instance exercises the auto timer.
module tb_aquarium_status_reader;
  logic CLK = 0, reset = 1, start = 0, ready = 0;
  logic [7:0] q [4];
  logic [7:0] out_data, a_data;
  logic out_valid, busy, frame_done, missed;
  logic a_valid, a_busy, a_done, a_missed;
  int tests = 0, fails = 0;
  logic [7:0] sb [$];
  int rem = 0;
  bit e_done = 0, e_miss = 0;

  always #5 CLK = ~CLK;

  aquarium_status_reader dut (
    .CLK(CLK), .reset(reset), .start(start),
    .Q_tank_cleanliness(q[0]), .Q_tank_temperature(q[1]),
    .Q_tank_food_storage(q[2]), .Q_tank_saltiness(q[3]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(ready),
    .busy(busy), .frame_done(frame_done), .missed(missed));

  aquarium_status_reader #(.AUTO_PERIOD(20)) dut_a (
    .CLK(CLK), .reset(reset), .start(1'b0),
    .Q_tank_cleanliness(8'h01), .Q_tank_temperature(8'h02),
    .Q_tank_food_storage(8'h03), .Q_tank_saltiness(8'hF0),
    .out_data(a_data), .out_valid(a_valid), .out_ready(1'b1),
    .busy(a_busy), .frame_done(a_done), .missed(a_missed));

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // Reference model: a frame is six bytes owed to the sink once a request lands while idle.
  initial forever begin
    @(posedge CLK or posedge reset);
    if (reset) begin
      rem = 0;
      sb.delete();
      e_done = 0;
      e_miss = 0;
    end else begin
      e_done = 0;
      e_miss = 0;
      if (rem == 0) begin
        if (start) begin
          sb.push_back(8'hA5);
          for (int i = 0; i < 4; i++) sb.push_back(q[i]);
          sb.push_back(8'((int'(q[0]) + int'(q[1]) + int'(q[2]) + int'(q[3])) % 256));
          rem = 6;
        end
      end else begin
        e_miss = start;
        if (ready) begin
          rem--;
          e_done = rem == 0;
        end
      end
    end
  end

  // Monitor for the start-driven instance.
  initial forever begin
    @(negedge CLK);
    if (!reset) begin
      check("valid", out_valid, rem > 0);
      check("busy", busy, rem > 0);
      check("frame_done", frame_done, e_done);
      check("missed", missed, e_miss);
      if (out_valid) begin
        if (sb.size() == 0) check("sb_empty", 8'd1, 8'd0);
        else begin
          check("byte", out_data, sb[0]);
          if (ready) void'(sb.pop_front());
        end
      end else check("idle_data", out_data, 8'h00);
    end
  end

  // Monitor for the auto-triggered instance: fixed frame every 20 cycles, nothing missed.
  logic [7:0] a_exp [6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'hF0, 8'hF6};
  int ai = 0, a_cyc = 0, a_last = -1, a_frames = 0;
  bit a_pv = 0;
  initial forever begin
    @(negedge CLK);
    a_cyc++;
    if (reset) begin
      ai = 0;
      a_last = -1;
      a_pv = 0;
    end else begin
      if (a_missed) check("auto_missed", 8'(a_missed), 8'd0);
      if (a_valid && !a_pv) begin
        a_frames++;
        if (a_last >= 0) check("auto_period", 8'(a_cyc - a_last), 8'd20);
        a_last = a_cyc;
      end
      if (a_valid) begin
        check("auto_byte", a_data, a_exp[ai]);
        ai = (ai + 1) % 6;
      end
      a_pv = a_valid;
    end
  end

  initial begin
    bit seen;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    #1;
    check("rst_valid", out_valid, 8'd0);
    check("rst_busy", busy, 8'd0);
    check("rst_data", out_data, 8'd0);
    step(3);
    reset = 0;
    ready = 1;
    // Basic frame, then the same frame under alternating backpressure.
    start = 1; step(); start = 0; step(10);
    start = 1; step(); start = 0;
    for (int i = 0; i < 20; i++) begin ready = ~ready; step(); end
    ready = 1; step(4);
    // Snapshot must survive inputs changing right after capture; checksum wraps.
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    start = 1; step(); start = 0;
    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    step(10);
    // Dropped request mid-frame, then back-to-back request in the done cycle.
    q = '{8'h5A, 8'h01, 8'h80, 8'h7F};
    start = 1; step(); start = 0; step(3);
    start = 1; step(); start = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (frame_done) begin
        seen = 1;
        start = 1; step(); start = 0;
      end
    end
    if (!seen) check("done_timeout", 8'd0, 8'd1);
    step(10);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(7) == 0);
      ready = ($urandom_range(9) < 7);
      for (int k = 0; k < 4; k++) q[k] = 8'($urandom);
      step();
    end
    start = 0; ready = 1; step(10);
    // Asynchronous reset mid-frame, then a clean frame.
    q = '{8'h10, 8'h20, 8'h30, 8'h40};
    start = 1; step(); start = 0; step(3);
    reset = 1;
    #1;
    check("abort_valid", out_valid, 8'd0);
    check("abort_busy", busy, 8'd0);
    step();
    reset = 0;
    start = 1; step(); start = 0; step(10);
    step(60);
    tests++;
    if (a_frames < 3) begin
      fails++;
      $display("FAIL auto_frames: got %0d expected at least 3", a_frames);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
